// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes, response
// state encoding and condition-code reset values.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Response slot state; the FULL state is exactly rsp_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

  // Y86 condition codes.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bus between two requesters plus one consumer and the
// shared ALU. master = requesters/consumer side, slave = the arbiter.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_setcc;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_ovf;
  logic               cc_zf;
  logic               cc_sf;
  logic               cc_of;

  modport master (
    output req_valid, req_op, req_a, req_b, req_setcc, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf,
           cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_setcc, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf,
           cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: add/sub/and/xor with signed overflow flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  // Evaluate the selected operation and its overflow condition.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    result = '0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two requesters share one ALU. Round-robin grant, one op per cycle, result
// delivered through a single registered valid/ready response slot. Holds the
// Y86 condition codes, updated only by requester CC_REQ.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit CC_REQ = 1'b0
) (
  input logic               clk,
  input logic               reset,
  alu_rr_arbiter_if.slave   bus
);

  rsp_state_t       state_q, state_d;
  logic             ptr_q;
  logic             free;
  logic             grant;
  logic             grant_id;
  logic             setcc_sel;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic [WIDTH-1:0] result_q;
  logic             id_q;
  logic             ovf_q;
  cc_t              cc_q;

  // Arbitration and operand mux: grant only when the response slot can take a result.
  always_comb begin
    free      = (state_q == ST_EMPTY) || bus.rsp_ready;
    grant     = free && (|bus.req_valid);
    grant_id  = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
    op_sel    = grant_id ? bus.req_op[3:2] : bus.req_op[1:0];
    a_sel     = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    b_sel     = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    setcc_sel = bus.req_setcc[grant_id];
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (op_sel),
    .a      (a_sel),
    .b      (b_sel),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // Response-slot state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next state: fill on grant, empty on drain without a new grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !grant) state_d = ST_EMPTY;
    endcase
  end

  // Outputs: valid from state, one-hot ready from grant, response fields from registers.
  always_comb begin
    bus.rsp_valid  = (state_q == ST_FULL);
    bus.req_ready  = 2'b00;
    if (grant) bus.req_ready[grant_id] = 1'b1;
    bus.rsp_id     = id_q;
    bus.rsp_result = result_q;
    bus.rsp_ovf    = ovf_q;
    bus.cc_zf      = cc_q.zf;
    bus.cc_sf      = cc_q.sf;
    bus.cc_of      = cc_q.of;
  end

  // Round-robin pointer: favour the other requester after each grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ptr_q <= 1'b0;
    else if (grant) ptr_q <= ~grant_id;
  end

  // Response payload: loaded on grant, otherwise held (also across a plain drain).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      id_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (grant) begin
      result_q <= alu_result;
      id_q     <= grant_id;
      ovf_q    <= alu_ovf;
    end
  end

  // Condition codes: only the privileged requester with setcc may change them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_q <= CC_RESET;
    end else if (grant && (grant_id == CC_REQ) && setcc_sel) begin
      cc_q.zf <= (alu_result == '0);
      cc_q.sf <= alu_result[WIDTH-1];
      cc_q.of <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a response scoreboard and a
// reference model of grant order and condition codes.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.WIDTH(W)) bus ();

  alu_rr_arbiter #(.WIDTH(W), .CC_REQ(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic m_ptr, m_valid, m_zf, m_sf, m_of;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU computed one bit wider; overflow = the wide result does not fit.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic o);
    logic [W:0] ext;
    r = '0;
    o = 1'b0;
    case (op)
      ALU_ADD: begin ext = {a[W-1], a} + {b[W-1], b}; r = ext[W-1:0]; o = ext[W] ^ ext[W-1]; end
      ALU_SUB: begin ext = {a[W-1], a} - {b[W-1], b}; r = ext[W-1:0]; o = ext[W] ^ ext[W-1]; end
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
    bus.req_valid[i]      = v;
    bus.req_op[2*i +: 2]  = op;
    bus.req_a[W*i +: W]   = a;
    bus.req_b[W*i +: W]   = b;
    bus.req_setcc[i]      = sc;
  endtask

  task automatic model_reset();
    m_ptr   = 1'b0;
    m_valid = 1'b0;
    m_zf    = 1'b1;
    m_sf    = 1'b0;
    m_of    = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    logic [1:0]   exp_ready;
    logic         gid;
    logic         nvalid;
    exp_t         e;
    exp_t         f;
    #1;
    if (bus.req_valid == 2'b11)      gid = m_ptr;
    else if (bus.req_valid[0])       gid = 1'b0;
    else                             gid = 1'b1;
    exp_ready = 2'b00;
    if ((!m_valid || bus.rsp_ready) && (bus.req_valid != 2'b00)) exp_ready[gid] = 1'b1;
    chk({tag, ".req_ready"}, W'(bus.req_ready), W'(exp_ready));

    if (m_valid) begin
      chk({tag, ".sb_nonempty"}, W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        f = sb[0];
        chk({tag, ".rsp_result"}, bus.rsp_result, f.res);
        chk({tag, ".rsp_id"}, W'(bus.rsp_id), W'(f.id));
        chk({tag, ".rsp_ovf"}, W'(bus.rsp_ovf), W'(f.ovf));
        if (bus.rsp_ready) void'(sb.pop_front());
      end
    end

    nvalid = m_valid && !bus.rsp_ready;
    if (exp_ready != 2'b00) begin
      e.id = gid;
      model(bus.req_op[2*gid +: 2], bus.req_a[W*gid +: W], bus.req_b[W*gid +: W], e.res, e.ovf);
      sb.push_back(e);
      m_ptr  = ~gid;
      nvalid = 1'b1;
      if (gid == 1'b0 && bus.req_setcc[0]) begin
        m_zf = (e.res == '0);
        m_sf = e.res[W-1];
        m_of = e.ovf;
      end
    end

    @(posedge clk);
    @(negedge clk);
    m_valid = nvalid;
    chk({tag, ".rsp_valid"}, W'(bus.rsp_valid), W'(m_valid));
    chk({tag, ".cc"}, W'({bus.cc_zf, bus.cc_sf, bus.cc_of}), W'({m_zf, m_sf, m_of}));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_setcc = '0;
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst.rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("rst.rsp_result", bus.rsp_result, '0);
    chk("rst.rsp_id", W'(bus.rsp_id), W'(0));
    chk("rst.rsp_ovf", W'(bus.rsp_ovf), W'(0));
    chk("rst.cc", W'({bus.cc_zf, bus.cc_sf, bus.cc_of}), W'(3'b100));

    // Single add 5+7 with setcc
    set_req(0, 1'b1, ALU_ADD, 64'd5, 64'd7, 1'b1);
    cycle("single");
    chk("single.result12", bus.rsp_result, 64'd12);
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("single_drain");

    // Overflow on add, then sub to zero
    set_req(0, 1'b1, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    cycle("ovf_add");
    chk("ovf_add.result", bus.rsp_result, 64'h8000_0000_0000_0000);
    chk("ovf_add.ovf", W'(bus.rsp_ovf), W'(1));
    set_req(0, 1'b1, ALU_SUB, 64'd3, 64'd3, 1'b1);
    cycle("sub_zero");
    chk("sub_zero.cc", W'({bus.cc_zf, bus.cc_sf, bus.cc_of}), W'(3'b100));
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("sub_drain");

    // Logic ops from requester 1
    set_req(1, 1'b1, ALU_AND, 64'hF0F0, 64'hFF00, 1'b0);
    cycle("and");
    chk("and.result", bus.rsp_result, 64'hF000);
    set_req(1, 1'b1, ALU_XOR, 64'hFF, 64'h0F, 1'b0);
    cycle("xor");
    chk("xor.result", bus.rsp_result, 64'hF0);
    set_req(1, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("logic_drain");

    // Round robin; requester 1 setcc must not touch CC
    set_req(0, 1'b1, ALU_ADD, 64'd100, 64'd23, 1'b0);
    set_req(1, 1'b1, ALU_SUB, 64'd1, 64'd2, 1'b1);
    cycle("rr0");
    chk("rr0.id", W'(bus.rsp_id), W'(0));
    cycle("rr1");
    chk("rr1.id", W'(bus.rsp_id), W'(1));
    cycle("rr2");
    cycle("rr3");
    chk("rr3.id", W'(bus.rsp_id), W'(1));
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    set_req(1, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("rr_drain");

    // Backpressure: stall 3 cycles, then drain plus grant together
    set_req(0, 1'b1, ALU_XOR, 64'hAAAA, 64'h5555, 1'b1);
    set_req(1, 1'b1, ALU_AND, 64'hFFFF_0000, 64'h0FF0_0FF0, 1'b0);
    cycle("bp_fill");
    bus.rsp_ready = 1'b0;
    repeat (3) cycle("bp_stall");
    bus.rsp_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release.id", W'(bus.rsp_id), W'(1));
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    set_req(1, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("bp_drain");
    chk("bp.sb_empty", W'(sb.size()), W'(0));

    // Asynchronous reset while a response is held
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 64'd9, 64'd9, 1'b1);
    cycle("rst_fill");
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("midrst.rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("midrst.cc", W'({bus.cc_zf, bus.cc_sf, bus.cc_of}), W'(3'b100));
    chk("midrst.rsp_result", bus.rsp_result, '0);
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_SUB, 64'd1, 64'd2, 1'b0);
    set_req(1, 1'b1, ALU_ADD, 64'd4, 64'd4, 1'b0);
    cycle("post_rst");
    chk("post_rst.id_ptr0", W'(bus.rsp_id), W'(0));
    set_req(0, 1'b0, ALU_ADD, '0, '0, 1'b0);
    set_req(1, 1'b0, ALU_ADD, '0, '0, 1'b0);
    cycle("post_rst_drain");
    cycle("idle");
    chk("end.sb_empty", W'(sb.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
